// File: rtl/sad_pkg.sv
// sad_pkg
// Shared definitions for the SAD block accumulator.
//   PIX_W_DEF / BLK_N_DEF : default pixel width and maximum pairs per block
//   sad_acc_w()           : result width that cannot overflow for a full block
//   state_t               : controller states
package sad_pkg;

  localparam int PIX_W_DEF = 8;
  localparam int BLK_N_DEF = 16;

  // A block of blk_n absolute differences, each below 2**pix_w, sums to
  // less than 2**(pix_w + clog2(blk_n)).
  function automatic int sad_acc_w(input int pix_w, input int blk_n);
    return pix_w + $clog2(blk_n);
  endfunction

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ACCUM   = 3'd1,
    DRAIN   = 3'd2,
    RESOLVE = 3'd3,
    OUT     = 3'd4
  } state_t;

endpackage

// File: rtl/sad_csa_row.sv
// sad_csa_row
// Row of W independent 3:2 full-adder cells (carry-save adder), purely
// combinational. No carry ripples between bit positions.
//   x, y, z : three W-bit addends
//   s       : per-bit sum     (x ^ y ^ z)
//   c       : per-bit carry   (majority of x, y, z), weight 2 relative to s
module sad_csa_row #(
  parameter int W = 12
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  output logic [W-1:0] s,
  output logic [W-1:0] c
);

  assign s = x ^ y ^ z;
  assign c = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/sad_block_accumulator.sv
// sad_block_accumulator
// Streaming sum-of-absolute-differences engine. Pixel pairs arrive over a
// valid/ready handshake; |a-b| is registered, then folded into a carry-save
// accumulator. At block end a single carry-propagate add produces out_sad.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_ready   : input pair handshake (in_ready from state only)
//   in_a, in_b, in_last : pixel pair, last pair of block
//   out_valid/out_ready : result handshake
//   out_sad             : block SAD
//
// state   | meaning
// IDLE    | CS registers clear, waiting for first pair of a block
// ACCUM   | accepting pairs, folding previous |a-b| into CS registers
// DRAIN   | folding the final |a-b|, no input accepted
// RESOLVE | carry-propagate add of sum_r and shifted carry_r into out_sad
// OUT     | result held until consumer accepts it
module sad_block_accumulator
  import sad_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEF,
  parameter int BLK_N = BLK_N_DEF,
  parameter int ACC_W = sad_acc_w(PIX_W, BLK_N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_a,
  input  logic [PIX_W-1:0] in_b,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sad
);

  localparam int CNT_W = $clog2(BLK_N);

  state_t           state;
  logic [PIX_W-1:0] ad_r;
  logic             ad_vld_r;
  logic [CNT_W-1:0] cnt_r;
  logic [ACC_W-1:0] sum_r;
  logic [ACC_W-1:0] carry_r;

  logic             accept;
  logic             blk_end;
  logic [PIX_W-1:0] ad_now;
  logic [ACC_W-1:0] carry_sh;
  logic [ACC_W-1:0] ad_ext;
  logic [ACC_W-1:0] csa_s;
  logic [ACC_W-1:0] csa_c;
  logic             carry_msb_unused;

  assign in_ready = (state == IDLE) || (state == ACCUM);
  assign accept   = in_valid && in_ready;
  assign ad_now   = (in_a >= in_b) ? (in_a - in_b) : (in_b - in_a);
  // Implicit end on the BLK_N-th beat: counter is about to wrap.
  assign blk_end  = in_last || (cnt_r == CNT_W'(BLK_N - 1));

  // The carry MSB would shift out of the ACC_W window; it is zero because
  // the true total never exceeds ACC_W bits.
  assign carry_sh         = {carry_r[ACC_W-2:0], 1'b0};
  assign carry_msb_unused = carry_r[ACC_W-1];
  assign ad_ext           = ACC_W'(ad_r);

  sad_csa_row #(
    .W (ACC_W)
  ) u_csa (
    .x (sum_r),
    .y (carry_sh),
    .z (ad_ext),
    .s (csa_s),
    .c (csa_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ad_r      <= '0;
      ad_vld_r  <= 1'b0;
      cnt_r     <= '0;
      sum_r     <= '0;
      carry_r   <= '0;
      out_valid <= 1'b0;
      out_sad   <= '0;
    end else begin
      // ad_r is folded one edge after it loads, so a pair accepted in the
      // same cycle overlaps with the previous pair's fold.
      if (ad_vld_r) begin
        sum_r   <= csa_s;
        carry_r <= csa_c;
      end
      ad_vld_r <= accept;
      if (accept) begin
        ad_r  <= ad_now;
        cnt_r <= cnt_r + CNT_W'(1);
      end

      case (state)
        IDLE, ACCUM: begin
          if (accept) state <= blk_end ? DRAIN : ACCUM;
        end
        DRAIN: begin
          state <= RESOLVE;
        end
        RESOLVE: begin
          out_sad   <= sum_r + carry_sh;
          out_valid <= 1'b1;
          state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            sum_r     <= '0;
            carry_r   <= '0;
            cnt_r     <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_block_accumulator.sv
module tb_sad_block_accumulator;

  localparam int PIX_W = 8;
  localparam int BLK_N = 16;
  localparam int ACC_W = 12;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [PIX_W-1:0] in_a = '0;
  logic [PIX_W-1:0] in_b = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [ACC_W-1:0] out_sad;

  sad_block_accumulator #(
    .PIX_W (PIX_W),
    .BLK_N (BLK_N),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sad   (out_sad)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int ecount = 0;
  always @(posedge clk) ecount++;

  typedef struct {
    int sad;
    int edge_n;
  } exp_t;
  exp_t sbq[$];

  int model_sum = 0;
  int model_n   = 0;
  int rdy_mode  = 0;

  task automatic check(input bit ok, input string name, input int act, input int req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  // Consumer-side readiness: always, random, or left to the main sequence.
  initial forever begin
    @(posedge clk);
    #1;
    if (rdy_mode == 0) out_ready = 1'b1;
    else if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: compares each presented result against the scoreboard head.
  logic             prev_valid = 1'b0;
  logic [ACC_W-1:0] held = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sbq.size() == 0) begin
          check(1'b0, "unexpected_result", int'(out_sad), -1);
        end else begin
          check(out_sad == ACC_W'(sbq[0].sad), "sad", int'(out_sad), sbq[0].sad);
          check(ecount == sbq[0].edge_n, "latency_edge", ecount, sbq[0].edge_n);
        end
        held = out_sad;
      end else if (out_valid) begin
        check(out_sad == held, "sad_stable", int'(out_sad), int'(held));
      end
      if (out_valid) check(in_ready == 1'b0, "in_ready_in_out", int'(in_ready), 0);
      if (out_valid && out_ready && sbq.size() > 0) void'(sbq.pop_front());
      prev_valid = out_valid;
    end
  end

  // Reference model: a block is the running sum of |a-b| ending at in_last
  // or at the BLK_N-th pair; result appears 2 edges after the ending beat.
  task automatic drive_beat(input logic [7:0] a, input logic [7:0] b,
                            input logic last, output int acc_edge);
    int budget;
    int ad;
    budget   = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(negedge clk);
    while (!in_ready) begin
      budget++;
      if (budget > 200) begin
        check(1'b0, "accept_timeout", budget, 200);
        finish_run();
      end
      @(negedge clk);
    end
    acc_edge = ecount + 1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    ad = (int'(a) > int'(b)) ? int'(a) - int'(b) : int'(b) - int'(a);
    model_sum += ad;
    model_n++;
    if (last || model_n == BLK_N) begin
      sbq.push_back('{model_sum, acc_edge + 2});
      model_sum = 0;
      model_n   = 0;
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || out_valid) && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (n >= 500) check(1'b0, "drain_timeout", n, 500);
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check(1'b0, "valid_timeout", n, 50);
  endtask

  initial begin
    int e, e_last, e_next, part, len;
    logic [7:0] ra, rb;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check(out_valid == 1'b0, "rst_out_valid", int'(out_valid), 0);
    check(out_sad == '0, "rst_out_sad", int'(out_sad), 0);
    check(in_ready == 1'b1, "rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic block with explicit last
    rdy_mode = 0;
    drive_beat(8'd10, 8'd3, 1'b0, e);
    drive_beat(8'd3, 8'd10, 1'b0, e);
    drive_beat(8'd255, 8'd0, 1'b0, e);
    drive_beat(8'd0, 8'd0, 1'b1, e);
    wait_drain();

    // Implicit end at the BLK_N-th beat
    for (int i = 0; i < BLK_N; i++) drive_beat(8'd255, 8'd0, 1'b0, e);
    @(negedge clk);
    check(in_ready == 1'b0, "in_ready_after_implicit_end", int'(in_ready), 0);
    @(posedge clk);
    #1;
    wait_drain();

    // Output stall
    rdy_mode  = 2;
    out_ready = 1'b0;
    drive_beat(8'd5, 8'd9, 1'b1, e);
    wait_valid();
    repeat (5) begin
      @(negedge clk);
      check(out_valid == 1'b1, "stall_out_valid", int'(out_valid), 1);
      check(out_sad == ACC_W'(4), "stall_out_sad", int'(out_sad), 4);
      check(in_ready == 1'b0, "stall_in_ready", int'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    rdy_mode = 0;
    @(negedge clk);
    check(out_valid == 1'b0, "release_out_valid", int'(out_valid), 0);
    check(in_ready == 1'b1, "release_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    // Carry-chain stress; after the 4th accept the first three are folded
    drive_beat(8'h55, 8'h00, 1'b0, e);
    drive_beat(8'hAA, 8'h00, 1'b0, e);
    drive_beat(8'hFF, 8'h00, 1'b0, e);
    drive_beat(8'h01, 8'h00, 1'b1, e);
    part = 'h55 + 'hAA + 'hFF;
    check(ACC_W'(dut.sum_r + {dut.carry_r, 1'b0}) == ACC_W'(part), "cs_invariant",
          int'(ACC_W'(dut.sum_r + {dut.carry_r, 1'b0})), part);
    check(dut.sum_r != ACC_W'(part), "cs_redundant_form", int'(dut.sum_r), part);
    wait_drain();

    // Mid-block reset
    drive_beat(8'd100, 8'd0, 1'b0, e);
    drive_beat(8'd100, 8'd0, 1'b0, e);
    rst_n = 1'b0;
    #2;
    check(out_valid == 1'b0, "midrst_out_valid", int'(out_valid), 0);
    check(in_ready == 1'b1, "midrst_in_ready", int'(in_ready), 1);
    model_sum = 0;
    model_n   = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive_beat(8'd1, 8'd2, 1'b1, e);
    wait_drain();

    // Reset while holding a result: out_valid must drop without a clock
    rdy_mode  = 2;
    out_ready = 1'b0;
    drive_beat(8'd20, 8'd5, 1'b1, e);
    wait_valid();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check(out_valid == 1'b0, "async_rst_out_valid", int'(out_valid), 0);
    if (sbq.size() > 0) void'(sbq.pop_front());
    @(posedge clk);
    #1;
    rst_n    = 1'b1;
    rdy_mode = 0;
    @(posedge clk);
    #1;

    // Back-to-back blocks with continuous valid
    drive_beat(8'd3, 8'd1, 1'b0, e);
    drive_beat(8'd1, 8'd3, 1'b1, e_last);
    drive_beat(8'd7, 8'd0, 1'b1, e_next);
    check(e_next - e_last == 4, "b2b_gap_edges", e_next - e_last, 4);
    wait_drain();

    // Randomized blocks, random gaps and random consumer readiness
    rdy_mode = 1;
    for (int blk = 0; blk < 40; blk++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        ra = 8'($urandom_range(0, 255));
        rb = 8'($urandom_range(0, 255));
        drive_beat(ra, rb, (i == len - 1), e);
      end
    end
    wait_drain();
    rdy_mode = 0;

    check(sbq.size() == 0, "scoreboard_empty", sbq.size(), 0);
    finish_run();
  end

endmodule
